// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Next-PC redirect unit. Keeps a circular queue of up to BR_DEPTH
//   unresolved conditional branches (target and fall-through), resolves
//   them oldest-first from WBU, and arbitrates every redirect source into
//   a single combinational dnpc/dnpc_valid pair. Also produces the
//   registered IFU fetch enable.
//
//   Parameters
//     XLEN      datapath / PC width
//     BR_DEPTH  max in-flight unresolved branches (power of 2, >= 1)
//     SPECULATE 0: stall fetch while any branch is pending
//               1: predict not-taken, stall only while the queue is full
//
//   Ports
//     clk, rst_n             clock, synchronous active-low reset
//     id_pc, id_imm, id_rs1  IDU operands
//     id_branch              push a conditional branch
//     id_jal, id_jalr        unconditional jumps from IDU
//     wb_branch, wb_taken    resolve (pop) the oldest branch and its outcome
//     mret, ecall            trap return / trap entry retiring
//     mepc, mtvec            CSR targets
//     dnpc, dnpc_valid       combinational redirect (dnpc is 0 when not valid)
//     fetch_en               registered IFU fetch enable
//     pending                number of queued branches
//     underflow              sticky: resolution seen with an empty queue
module pc_redirect_unit #(
    parameter int XLEN      = 32,
    parameter int BR_DEPTH  = 2,
    parameter int SPECULATE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [XLEN-1:0]             id_pc,
    input  logic [XLEN-1:0]             id_imm,
    input  logic [XLEN-1:0]             id_rs1,
    input  logic                        id_branch,
    input  logic                        id_jal,
    input  logic                        id_jalr,
    input  logic                        wb_branch,
    input  logic                        wb_taken,
    input  logic                        mret,
    input  logic                        ecall,
    input  logic [XLEN-1:0]             mepc,
    input  logic [XLEN-1:0]             mtvec,
    output logic [XLEN-1:0]             dnpc,
    output logic                        dnpc_valid,
    output logic                        fetch_en,
    output logic [$clog2(BR_DEPTH):0]   pending,
    output logic                        underflow
);

    localparam int PTR_W = (BR_DEPTH > 1) ? $clog2(BR_DEPTH) : 1;
    localparam int CNT_W = $clog2(BR_DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BR_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BR_DEPTH);
    localparam bit SPEC = (SPECULATE != 0);

    logic [XLEN-1:0]  q_target   [BR_DEPTH];
    logic [XLEN-1:0]  q_fallthru [BR_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic             q_empty;
    logic             q_full;
    logic             do_pop;
    logic             do_push;
    logic             squash;
    logic [CNT_W-1:0] pending_next;
    logic [XLEN-1:0]  jalr_sum;

    // Pointers wrap explicitly so non-power-of-2 pointer widths (depth 1)
    // still behave.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        q_empty  = (pending == '0);
        q_full   = (pending == CNT_FULL);
        do_pop   = wb_branch && !q_empty;
        do_push  = id_branch && !q_full;
        // A taken branch under speculation, or any trap entry/return, kills
        // every younger queued branch including one being pushed now.
        squash   = mret || ecall || (SPEC && do_pop && wb_taken);
        jalr_sum = id_rs1 + id_imm;

        pending_next = pending;
        if (squash) begin
            pending_next = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   pending_next = pending + CNT_W'(1);
                2'b01:   pending_next = pending - CNT_W'(1);
                default: pending_next = pending;
            endcase
        end

        // Redirect arbitration. A silent not-taken pop under speculation
        // does not win, so lower sources may still redirect that cycle.
        dnpc       = '0;
        dnpc_valid = 1'b0;
        if (do_pop && (!SPEC || wb_taken)) begin
            dnpc_valid = 1'b1;
            dnpc       = wb_taken ? q_target[head] : q_fallthru[head];
        end else if (mret) begin
            dnpc_valid = 1'b1;
            dnpc       = mepc;
        end else if (ecall) begin
            dnpc_valid = 1'b1;
            dnpc       = mtvec;
        end else if (id_jalr) begin
            dnpc_valid = 1'b1;
            dnpc       = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (id_jal) begin
            dnpc_valid = 1'b1;
            dnpc       = id_pc + id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            pending   <= '0;
            fetch_en  <= 1'b1;
            underflow <= 1'b0;
            for (int i = 0; i < BR_DEPTH; i++) begin
                q_target[i]   <= '0;
                q_fallthru[i] <= '0;
            end
        end else begin
            pending  <= pending_next;
            fetch_en <= SPEC ? (pending_next < CNT_FULL) : (pending_next == '0);
            if (wb_branch && q_empty)
                underflow <= 1'b1;
            if (squash) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_push) begin
                    q_target[tail]   <= id_pc + id_imm;
                    q_fallthru[tail] <= id_pc + XLEN'(4);
                    tail             <= ptr_inc(tail);
                end
                if (do_pop)
                    head <= ptr_inc(head);
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: three instances (stall D=2, speculate D=2,
// speculate D=4) share one input stream and are compared against a
// queue-based reference model, plus directed checks with fixed values.
module tb_pc_redirect_unit;

    localparam int N = 3;
    localparam int SPECS  [N] = '{0, 1, 1};
    localparam int DEPTHS [N] = '{2, 2, 4};

    logic        clk = 0;
    logic        rst_n;
    logic [31:0] id_pc, id_imm, id_rs1, mepc, mtvec;
    logic        id_branch, id_jal, id_jalr, wb_branch, wb_taken, mret, ecall;

    logic [31:0] dnpc_o [N];
    logic        valid_o [N];
    logic        fe_o [N];
    logic        uf_o [N];
    logic [1:0]  pend0, pend1;
    logic [2:0]  pend2;
    logic [7:0]  pend_v [N];

    assign pend_v[0] = 8'(pend0);
    assign pend_v[1] = 8'(pend1);
    assign pend_v[2] = 8'(pend2);

    always #5 clk = ~clk;

    pc_redirect_unit #(.XLEN(32), .BR_DEPTH(2), .SPECULATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr),
        .wb_branch(wb_branch), .wb_taken(wb_taken), .mret(mret), .ecall(ecall),
        .mepc(mepc), .mtvec(mtvec), .dnpc(dnpc_o[0]), .dnpc_valid(valid_o[0]),
        .fetch_en(fe_o[0]), .pending(pend0), .underflow(uf_o[0]));

    pc_redirect_unit #(.XLEN(32), .BR_DEPTH(2), .SPECULATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr),
        .wb_branch(wb_branch), .wb_taken(wb_taken), .mret(mret), .ecall(ecall),
        .mepc(mepc), .mtvec(mtvec), .dnpc(dnpc_o[1]), .dnpc_valid(valid_o[1]),
        .fetch_en(fe_o[1]), .pending(pend1), .underflow(uf_o[1]));

    pc_redirect_unit #(.XLEN(32), .BR_DEPTH(4), .SPECULATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr),
        .wb_branch(wb_branch), .wb_taken(wb_taken), .mret(mret), .ecall(ecall),
        .mepc(mepc), .mtvec(mtvec), .dnpc(dnpc_o[2]), .dnpc_valid(valid_o[2]),
        .fetch_en(fe_o[2]), .pending(pend2), .underflow(uf_o[2]));

    // Reference model: a plain FIFO of {target, fallthrough} per instance.
    typedef struct packed {
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;

    ent_t mq [N][$];
    bit   m_uf [N];
    bit   m_fe [N];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_comb(input int k, output logic [31:0] d, output logic v);
        logic [31:0] s;
        d = 0;
        v = 0;
        s = id_rs1 + id_imm;
        if (wb_branch && mq[k].size() > 0 && (SPECS[k] == 0 || wb_taken)) begin
            v = 1;
            d = wb_taken ? mq[k][0].tgt : mq[k][0].ft;
        end else if (mret) begin
            v = 1; d = mepc;
        end else if (ecall) begin
            v = 1; d = mtvec;
        end else if (id_jalr) begin
            v = 1; d = s & 32'hFFFF_FFFE;
        end else if (id_jal) begin
            v = 1; d = id_pc + id_imm;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                m_uf[k] = 0;
                m_fe[k] = 1;
            end else begin
                bit resolve, was_full, kill;
                ent_t e;
                resolve  = wb_branch && mq[k].size() > 0;
                was_full = (mq[k].size() == DEPTHS[k]);
                kill     = mret || ecall || (resolve && SPECS[k] != 0 && wb_taken);
                if (wb_branch && mq[k].size() == 0) m_uf[k] = 1;
                if (kill) begin
                    mq[k].delete();
                end else begin
                    if (resolve) void'(mq[k].pop_front());
                    if (id_branch && !was_full) begin
                        e.tgt = id_pc + id_imm;
                        e.ft  = id_pc + 32'd4;
                        mq[k].push_back(e);
                    end
                end
                m_fe[k] = (SPECS[k] != 0) ? (mq[k].size() < DEPTHS[k]) : (mq[k].size() == 0);
            end
        end
    endtask

    // One clock: check combinational outputs, clock the model, check state.
    task automatic tick();
        logic [31:0] d;
        logic        v;
        #1;
        for (int k = 0; k < N; k++) begin
            model_comb(k, d, v);
            chk($sformatf("dnpc%0d", k), 64'(dnpc_o[k]), 64'(d));
            chk($sformatf("dnpc_valid%0d", k), 64'(valid_o[k]), 64'(v));
        end
        @(posedge clk);
        model_clock();
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("pending%0d", k), 64'(pend_v[k]), 64'(mq[k].size()));
            chk($sformatf("fetch_en%0d", k), 64'(fe_o[k]), 64'(m_fe[k]));
            chk($sformatf("underflow%0d", k), 64'(uf_o[k]), 64'(m_uf[k]));
        end
    endtask

    task automatic idle();
        id_pc = 0; id_imm = 0; id_rs1 = 0; mepc = 0; mtvec = 0;
        id_branch = 0; id_jal = 0; id_jalr = 0;
        wb_branch = 0; wb_taken = 0; mret = 0; ecall = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] imm);
        idle();
        id_pc = pc; id_imm = imm; id_branch = 1;
        tick();
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(negedge clk);
        do_reset();
        do_reset();
        chk("rst_pending", 64'(pend0), 64'd0);
        chk("rst_fetch_en", 64'(fe_o[0]), 64'd1);
        chk("rst_underflow", 64'(uf_o[0]), 64'd0);

        // Stall mode: taken and not-taken resolution
        push(32'h100, 32'h20);
        chk("s0_pending", 64'(pend0), 64'd1);
        chk("s0_fetch_stall", 64'(fe_o[0]), 64'd0);
        wb_branch = 1; wb_taken = 1;
        #1;
        chk("s0_taken_dnpc", 64'(dnpc_o[0]), 64'h120);
        chk("s0_taken_valid", 64'(valid_o[0]), 64'd1);
        tick();
        idle();
        chk("s0_fetch_resume", 64'(fe_o[0]), 64'd1);
        chk("s0_pending_zero", 64'(pend0), 64'd0);
        push(32'h100, 32'h20);
        wb_branch = 1; wb_taken = 0;
        #1;
        chk("s0_nt_dnpc", 64'(dnpc_o[0]), 64'h104);
        tick();
        idle();

        // Speculate D=2: fill, drop, silent not-taken, taken
        do_reset();
        push(32'h200, 32'h10);
        push(32'h208, 32'h40);
        chk("s1_pending_full", 64'(pend1), 64'd2);
        chk("s1_fetch_full", 64'(fe_o[1]), 64'd0);
        push(32'h210, 32'h80);
        chk("s1_drop_pending", 64'(pend1), 64'd2);
        wb_branch = 1; wb_taken = 0;
        #1;
        chk("s1_nt_silent", 64'(valid_o[1]), 64'd0);
        tick();
        idle();
        chk("s1_nt_pending", 64'(pend1), 64'd1);
        chk("s1_nt_fetch", 64'(fe_o[1]), 64'd1);
        wb_branch = 1; wb_taken = 1;
        #1;
        chk("s1_taken_dnpc", 64'(dnpc_o[1]), 64'h248);
        tick();
        idle();

        // Squash of a concurrent push
        do_reset();
        push(32'h200, 32'h10);
        push(32'h208, 32'h40);
        wb_branch = 1; wb_taken = 1;
        id_branch = 1; id_pc = 32'h300; id_imm = 32'h8;
        #1;
        chk("sq_dnpc", 64'(dnpc_o[1]), 64'h210);
        tick();
        idle();
        chk("sq_pending", 64'(pend1), 64'd0);

        // Priority
        do_reset();
        push(32'h100, 32'h20);
        wb_branch = 1; wb_taken = 1; mret = 1; mepc = 32'h500;
        id_jal = 1; id_pc = 32'h400; id_imm = 32'h4;
        #1;
        chk("pri_branch", 64'(dnpc_o[0]), 64'h120);
        tick();
        idle();
        mret = 1; mepc = 32'h500; id_jalr = 1; id_rs1 = 32'h301; id_imm = 0;
        #1;
        chk("pri_mret", 64'(dnpc_o[0]), 64'h500);
        tick();
        idle();
        id_jalr = 1; id_rs1 = 32'h301; id_imm = 0;
        #1;
        chk("pri_jalr", 64'(dnpc_o[0]), 64'h300);
        tick();
        idle();

        // Underflow is sticky until reset
        do_reset();
        wb_branch = 1; wb_taken = 1;
        #1;
        chk("uf_no_redirect", 64'(valid_o[0]), 64'd0);
        tick();
        idle();
        chk("uf_set", 64'(uf_o[0]), 64'd1);
        push(32'h40, 32'h8);
        tick();
        chk("uf_sticky", 64'(uf_o[0]), 64'd1);
        do_reset();
        chk("uf_cleared", 64'(uf_o[0]), 64'd0);

        // Pointer wrap on D=4
        for (int i = 0; i < 10; i++) begin
            push(32'h1000 + 32'(16 * i), 32'h0);
            chk("wrap_pend_le1", 64'(pend2 <= 3'd1), 64'd1);
            wb_branch = 1; wb_taken = 1;
            #1;
            chk("wrap_dnpc", 64'(dnpc_o[2]), 64'(32'h1000 + 32'(16 * i)));
            tick();
            idle();
        end

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            id_pc     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            id_imm    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            id_rs1    = $urandom;
            mepc      = $urandom;
            mtvec     = $urandom;
            id_branch = ($urandom_range(0, 1) == 0);
            wb_branch = ($urandom_range(0, 4) < 2);
            wb_taken  = $urandom_range(0, 1) != 0;
            mret      = ($urandom_range(0, 19) == 0);
            ecall     = ($urandom_range(0, 19) == 0);
            id_jal    = ($urandom_range(0, 6) == 0);
            id_jalr   = ($urandom_range(0, 6) == 0);
            tick();
        end
        rst_n = 1;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Parametrised next-PC redirect unit for the NPC core. It replaces the single-branch PC control with a queue of up to `BR_DEPTH` unresolved conditional branches. It has two modes: stall-on-branch (`SPECULATE=0`) and predict-not-taken with squash on taken (`SPECULATE=1`). It sits between IDU/WBU and the IFU PC register, producing `dnpc`/`dnpc_valid` and a fetch enable.

## Interface
- `XLEN`, 32: datapath/PC width.
- `BR_DEPTH`, 2: max in-flight unresolved conditional branches (≥1, power of 2).
- `SPECULATE`, 0: 0 = stall fetch while any branch is pending; 1 = predict not-taken, stall only when the queue is full.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `id_pc`  in  XLEN  PC of instruction in IDU.
- `id_imm`  in  XLEN  decoded immediate.
- `id_rs1`  in  XLEN  rs1 operand value.
- `id_branch`  in  1  IDU issues a conditional branch this cycle (push).
- `id_jal`  in  1  IDU jal.
- `id_jalr`  in  1  IDU jalr.
- `wb_branch`  in  1  WBU resolves the oldest pending branch (pop).
- `wb_taken`  in  1  resolution outcome, valid with `wb_branch`.
- `mret`  in  1  mret retiring.
- `ecall`  in  1  ecall retiring.
- `mepc`  in  XLEN  CSR mepc.
- `mtvec`  in  XLEN  CSR mtvec.
- `dnpc`  out  XLEN  redirect target; 0 when `dnpc_valid`=0.
- `dnpc_valid`  out  1  redirect this cycle.
- `fetch_en`  out  1  IFU may fetch (registered).
- `pending`  out  clog2(BR_DEPTH)+1  branches in queue.
- `underflow`  out  1  sticky: `wb_branch` seen with empty queue.

## Operation
- Queue: circular FIFO, `BR_DEPTH` entries, each holds {target = id_pc+id_imm, fallthru = id_pc+4}. All adds are modulo 2^XLEN, carry dropped.
- Push on `id_branch` when the queue is not full. Push when full is dropped, and the queue is unchanged.
- Pop on `wb_branch` when the queue is not empty. Pop when empty sets `underflow` (cleared only by reset) and produces no redirect.
- Redirect priority, highest first. Only the winner drives `dnpc`.
  1. Resolution: `wb_branch` with a non-empty queue.
     - `SPECULATE=0`: always redirect; `dnpc` = head.target if `wb_taken`, else head.fallthru.
     - `SPECULATE=1`: redirect only if `wb_taken`, with `dnpc` = head.target; not-taken pops silently.
  2. `mret`: `dnpc` = `mepc`.
  3. `ecall`: `dnpc` = `mtvec`.
  4. `id_jalr`: `dnpc` = (`id_rs1`+`id_imm`) & ~1.
  5. `id_jal`: `dnpc` = `id_pc`+`id_imm`.
- Squash: a taken resolution in `SPECULATE=1`, or any `mret`/`ecall`, empties the queue (head=tail=0, `pending`=0). A simultaneous `id_branch` push is discarded (younger, squashed).
- Simultaneous push and pop without squash: head and tail both advance, `pending` unchanged. Push into an empty queue concurrent with a pop is the underflow case; the push is kept.
- Next-state `fetch_en`:
  - `SPECULATE=0`: `pending_next`==0.
  - `SPECULATE=1`: `pending_next` < `BR_DEPTH`.
- Pointers wrap from `BR_DEPTH-1` to 0.

## Timing
- Reset (`rst_n`=0 at posedge): `pending`=0, pointers 0, `fetch_en`=1, `underflow`=0, queue contents cleared to 0.
- `dnpc`/`dnpc_valid` are combinational: same cycle as the causing input, zero latency. With no redirect, both are 0.
- Queue, `pending`, `fetch_en` and `underflow` update at posedge clk. `fetch_en` reflects the post-edge state, so it drops the cycle after a push that fills the queue (`SPECULATE=1`) or makes it non-empty (`SPECULATE=0`). It rises the cycle after the emptying or freeing pop.
- Reset mid-operation overrides all inputs in that cycle. Outstanding entries are lost and no redirect is remembered.

## Test plan
- Reset, then `SPECULATE=0`, id_pc=0x100, id_imm=0x20, id_branch=1 → next cycle `pending`=1, `fetch_en`=0. Then wb_branch=1, wb_taken=1 → `dnpc`=0x120, `dnpc_valid`=1 same cycle; next cycle `fetch_en`=1, `pending`=0. Repeat with wb_taken=0 → `dnpc`=0x104.
- `SPECULATE=1`, `BR_DEPTH`=2: push 0x200/+0x10, then 0x208/+0x40 → `pending`=2, `fetch_en`=0. A third push is dropped. Resolve not-taken → no redirect, `pending`=1, `fetch_en`=1. Resolve taken → `dnpc`=0x248.
- `SPECULATE=1`, two pending, taken resolution with concurrent id_branch → `dnpc`=head.target; next cycle `pending`=0 (push squashed).
- Priority: wb_branch taken + mret + id_jal in the same cycle → `dnpc` = branch target. mret + id_jalr (rs1=0x301, imm=0) → `dnpc`=`mepc`. id_jalr alone → 0x300.
- wb_branch with empty queue → `dnpc_valid`=0, `underflow`=1 and it stays 1 until rst_n=0.
- Wrap: `BR_DEPTH`=4, 10 alternating push/pop pairs with targets 0x1000+16·i → each pop redirects to the matching target in order; `pending` never exceeds 1.
